m_stage: RTL and testbench
==========================

# m_stage

Clocked two-way merge stage for the data-driven pipeline; the converging counterpart of the branch stage. Accepts packets from two upstream Send/Ack channels (a, b), arbitrates round-robin, and forwards them in order through a 2-entry output buffer onto a single Send/Ack channel. Sits where two branch paths rejoin before the next functional stage.

## Interface
- PW, 24: packet width in bits on each input channel.
- CLK  in  1  rising-edge clock.
- MR  in  1  master reset, asynchronous, active-low.
- Send_in_a / Send_in_b  in  1  upstream channel a/b holds a valid packet.
- PACKET_IN_A / PACKET_IN_B  in  PW  packet on channel a/b, stable while Send_in_x is high.
- Ack_out_a / Ack_out_b  out  1  channel a/b packet accepted this cycle.
- Send_out  out  1  output buffer non-empty; PACKET_OUT valid.
- Ack_in  in  1  downstream takes PACKET_OUT this cycle.
- PACKET_OUT  out  PW (PW+1 with tag)  head of output buffer.

## Operation
- Transfer rule, both sides: a packet moves on a rising CLK edge where Send and Ack are both high. Upstream holds Send_in_x and PACKET_IN_x until it sees Ack_out_x high at an edge.
- Ack_out_x is combinational from Send_in_x, the arbiter pointer and buffer count only; never from Ack_in (no Ack_in→Ack_out path).
- Accept condition: count < 2. At most one input accepted per cycle.
- Arbitration (m_arb): only a requests → a; only b → b; both → the channel not equal to last_grant. last_grant updates only on an actual accept. Reset value last_grant = B, so a wins the first tie.
- Buffer: 2 entries, wr_ptr/rd_ptr 1 bit each, count 0..2. Push on accept, pop on Send_out && Ack_in. Push+pop same cycle: count unchanged, both pointers advance. Order preserved.
- Send_out = (count != 0); PACKET_OUT = entry[rd_ptr] (registered; no combinational path from PACKET_IN).
- Full (count = 2): Ack_out_a = Ack_out_b = 0 even if Ack_in high that cycle; acceptance resumes the cycle after the pop.
- Empty: Send_out = 0; PACKET_OUT holds last value (don't-care).
- Reset (MR low, any time, including mid-transfer): count = 0, pointers = 0, last_grant = B, Send_out = 0, Ack_out_a/b = 0 while MR low, PACKET_OUT = 0. Buffered packets are discarded.

## Timing
- Latency: packet accepted at edge N appears on PACKET_OUT with Send_out high after edge N (visible in cycle N+1) when buffer was empty.
- Throughput: 1 packet/cycle sustained when Ack_in is held high.
- Ack_out_x is valid in the same cycle as Send_in_x (combinational, single gate level after registers).
- Under continuous contention with Ack_in high, grants alternate a, b, a, b …; neither channel waits more than one accept.

## Configuration
- M_STAGE_SRC_TAG_EN defined: PACKET_OUT is PW+1 bits; MSB is source tag (0 = a, 1 = b) stored alongside each entry.
- Undefined: PACKET_OUT is PW bits, no tag storage; behaviour otherwise identical.

## Structure
- Shared header/package (with existing packet macros): PW default, SRC_A = 1'b0 / SRC_B = 1'b1 encoding, output-width macro derived from M_STAGE_SRC_TAG_EN.
- One sub-module: m_arb — 2-input round-robin arbiter (req_a, req_b, en, grant_a, grant_b, last_grant register).
- Buffer and pointers inline in m_stage.

## Test plan
- Reset: MR low mid-stream with count = 2 → Send_out = 0, Ack_out_a/b = 0, PACKET_OUT = 0; after release, first packet from a (0x00000A) emerges alone.
- Single source: Send_in_a with 0x000011, 0x000022, 0x000033, Ack_in = 1 → Ack_out_a high 3 consecutive cycles, PACKET_OUT 0x000011/22/33 one cycle after each accept.
- Contention: a = 0x0000A1, b = 0x0000B1 both held, Ack_in = 1 → output order A1, B1, then a's next, b's next; grants strictly alternate starting with a.
- Backpressure: Ack_in = 0, a sends 3 packets → first two accepted, Ack_out_a = 0 at count = 2; raise Ack_in one cycle → one pop, third accepted next cycle, order preserved.
- Simultaneous push/pop at count = 1 → count stays 1, pointers advance, no loss or duplication over 100 random-stall cycles versus scoreboard.
- M_STAGE_SRC_TAG_EN defined: b sends 0x000055 → PACKET_OUT = {1'b1, 0x000055}; a sends 0x000066 → {1'b0, 0x000066}.

Source files
------------

// File: rtl/m_stage_pkg.sv
// m_stage_pkg: shared definitions for the two-way merge stage.
// Optional feature macro: M_STAGE_SRC_TAG_EN (adds a 1-bit source tag as the
// MSB of every buffered packet and of PACKET_OUT).

`ifndef M_STAGE_PKG_SV
`define M_STAGE_PKG_SV

// Output packet width derived from the payload width and the tag option.
`ifdef M_STAGE_SRC_TAG_EN
`define M_STAGE_OUT_W(pw) ((pw) + 1)
`else
`define M_STAGE_OUT_W(pw) (pw)
`endif

package m_stage_pkg;

  // Default payload width of each input channel.
  localparam int M_PW = 24;

  // Source encoding, used both for the arbiter history and the packet tag.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Output buffer depth; pointers are 1 bit, occupancy spans 0..2.
  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] count_t;

  // The stage may accept a new packet only while the buffer has a free slot.
  function automatic logic can_accept(input count_t count);
    return count < 2'(BUF_DEPTH);
  endfunction

endpackage

`endif

// File: rtl/m_arb.sv
// m_arb: 2-input round-robin arbiter. Grants are combinational from the
// requests, the enable and the registered last_grant; the history only moves
// when a grant is actually issued, so idle cycles do not disturb fairness.

module m_arb
  import m_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic grant_a,
  output logic grant_b
);

  logic last_grant_reg;

  // Single request wins outright; on a tie the channel not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        grant_a = (last_grant_reg == SRC_B);
        grant_b = (last_grant_reg == SRC_A);
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  // Remember who was served; reset to B so that a wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= SRC_B;
    end else if (grant_a) begin
      last_grant_reg <= SRC_A;
    end else if (grant_b) begin
      last_grant_reg <= SRC_B;
    end
  end

endmodule

// File: rtl/m_stage.sv
// m_stage: clocked two-way merge stage. Two Send/Ack inputs are arbitrated
// round-robin into a 2-entry in-order buffer feeding one Send/Ack output.
// Ack_out_x depends only on Send_in_x, the arbiter history, the occupancy and
// MR -- never on Ack_in -- so a full buffer refuses input even in the cycle it
// is being drained.
// Optional feature macro: M_STAGE_SRC_TAG_EN (PACKET_OUT = {src_tag, packet}).

module m_stage
  import m_stage_pkg::*;
#(
  parameter int PW = M_PW
) (
  input  logic                           CLK,
  input  logic                           MR,
  input  logic                           Send_in_a,
  input  logic                           Send_in_b,
  input  logic [PW-1:0]                  PACKET_IN_A,
  input  logic [PW-1:0]                  PACKET_IN_B,
  output logic                           Ack_out_a,
  output logic                           Ack_out_b,
  output logic                           Send_out,
  input  logic                           Ack_in,
  output logic [`M_STAGE_OUT_W(PW)-1:0]  PACKET_OUT
);

  localparam int OW = `M_STAGE_OUT_W(PW);

  count_t         count_reg;
  count_t         count_next;
  logic           wr_ptr_reg;
  logic           rd_ptr_reg;
  logic [OW-1:0]  entry_reg [BUF_DEPTH];

  logic           accept_en;
  logic           grant_a;
  logic           grant_b;
  logic           push;
  logic           pop;
  logic [OW-1:0]  push_data;

  // Acceptance is gated by free space and held off while reset is asserted.
  assign accept_en = MR && can_accept(count_reg);

  m_arb u_arb (
    .clk     (CLK),
    .rst_n   (MR),
    .req_a   (Send_in_a),
    .req_b   (Send_in_b),
    .en      (accept_en),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign Ack_out_a = grant_a;
  assign Ack_out_b = grant_b;

  assign push     = grant_a || grant_b;
  assign Send_out = (count_reg != 2'd0);
  assign pop      = Send_out && Ack_in;

  // Select the granted packet, prefixing the source tag when enabled.
  always_comb begin
`ifdef M_STAGE_SRC_TAG_EN
    push_data = grant_b ? {SRC_B, PACKET_IN_B} : {SRC_A, PACKET_IN_A};
`else
    push_data = grant_b ? PACKET_IN_B : PACKET_IN_A;
`endif
  end

  // Occupancy: push and pop in the same cycle leave it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Occupancy and ring pointers; 1-bit pointers wrap naturally over 2 slots.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // Buffer storage; cleared on reset so PACKET_OUT reads 0 afterwards.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (push) begin
      entry_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Head of the buffer comes straight from storage, never from PACKET_IN.
  assign PACKET_OUT = entry_reg[rd_ptr_reg];

endmodule

// File: tb/tb_m_stage.sv
// tb_m_stage: randomized scoreboard bench for m_stage. A behavioural model
// (queue of in-flight packets plus a "last served" flag) predicts the
// acknowledges and the output stream; a negedge monitor compares the DUT.

`timescale 1ns/1ps

module tb_m_stage;

  localparam int PW = 24;
`ifdef M_STAGE_SRC_TAG_EN
  localparam int OW = PW + 1;
`else
  localparam int OW = PW;
`endif

  logic          CLK = 1'b0;
  logic          MR;
  logic          Send_in_a;
  logic          Send_in_b;
  logic [PW-1:0] PACKET_IN_A;
  logic [PW-1:0] PACKET_IN_B;
  logic          Ack_out_a;
  logic          Ack_out_b;
  logic          Send_out;
  logic          Ack_in;
  logic [OW-1:0] PACKET_OUT;

  always #5 CLK = ~CLK;

  m_stage #(.PW(PW)) dut (
    .CLK         (CLK),
    .MR          (MR),
    .Send_in_a   (Send_in_a),
    .Send_in_b   (Send_in_b),
    .PACKET_IN_A (PACKET_IN_A),
    .PACKET_IN_B (PACKET_IN_B),
    .Ack_out_a   (Ack_out_a),
    .Ack_out_b   (Ack_out_b),
    .Send_out    (Send_out),
    .Ack_in      (Ack_in),
    .PACKET_OUT  (PACKET_OUT)
  );

  int errors = 0;
  int checks = 0;

  // Model state (written only by the monitor process).
  logic [OW-1:0] exp_q[$];
  logic          model_last_b;
  logic          gnt_a_q;
  logic          gnt_b_q;

  // Upstream sources (written only by the stimulus process).
  logic [PW-1:0] src_a[$];
  logic [PW-1:0] src_b[$];
  logic          hold_a;
  logic          hold_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] mk(input logic src, input logic [PW-1:0] d);
    logic [PW:0] t;
    t = {src, d};
    return OW'(t);
  endfunction

  // Monitor + reference model: evaluated mid-cycle, when inputs are stable
  // for the coming edge and DUT outputs reflect the previous edge.
  always @(negedge CLK) begin
    int   cnt;
    logic ea;
    logic eb;
    if (!MR) begin
      exp_q.delete();
      model_last_b = 1'b1;
      gnt_a_q      = 1'b0;
      gnt_b_q      = 1'b0;
    end else begin
      cnt = exp_q.size();
      ea  = 1'b0;
      eb  = 1'b0;
      if (cnt < 2) begin
        if (Send_in_a && Send_in_b) begin
          ea = model_last_b;
          eb = !model_last_b;
        end else begin
          ea = Send_in_a;
          eb = Send_in_b;
        end
      end
      check("ack_out_a", 32'(Ack_out_a), 32'(ea));
      check("ack_out_b", 32'(Ack_out_b), 32'(eb));
      check("send_out", 32'(Send_out), 32'(cnt != 0));
      if (Send_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(PACKET_OUT), 32'hFFFF_FFFF);
        end else begin
          check("packet_out", 32'(PACKET_OUT), 32'(exp_q[0]));
          if (Ack_in) begin
            $display("xfer out=%0h t=%0t", exp_q[0], $time);
            void'(exp_q.pop_front());
          end
        end
      end
      if (ea) begin
        exp_q.push_back(mk(1'b0, PACKET_IN_A));
        model_last_b = 1'b0;
      end else if (eb) begin
        exp_q.push_back(mk(1'b1, PACKET_IN_B));
        model_last_b = 1'b1;
      end
      gnt_a_q = ea;
      gnt_b_q = eb;
    end
  end

  // One cycle of upstream/downstream behaviour, driven just after the edge.
  task automatic step(input int p_send, input int p_ack);
    @(posedge CLK);
    #1;
    if (gnt_a_q && src_a.size() != 0) begin
      void'(src_a.pop_front());
      hold_a = 1'b0;
    end
    if (gnt_b_q && src_b.size() != 0) begin
      void'(src_b.pop_front());
      hold_b = 1'b0;
    end
    if (!hold_a && src_a.size() != 0 && int'($urandom_range(99)) < p_send) hold_a = 1'b1;
    if (!hold_b && src_b.size() != 0 && int'($urandom_range(99)) < p_send) hold_b = 1'b1;
    Send_in_a   = hold_a;
    Send_in_b   = hold_b;
    PACKET_IN_A = hold_a ? src_a[0] : PW'($urandom);
    PACKET_IN_B = hold_b ? src_b[0] : PW'($urandom);
    Ack_in      = (int'($urandom_range(99)) < p_ack);
  endtask

  task automatic clear_sources();
    src_a.delete();
    src_b.delete();
    hold_a    = 1'b0;
    hold_b    = 1'b0;
    Send_in_a = 1'b0;
    Send_in_b = 1'b0;
  endtask

  initial begin
    MR          = 1'b0;
    Ack_in      = 1'b1;
    PACKET_IN_A = 24'h123456;
    PACKET_IN_B = 24'h654321;
    hold_a      = 1'b0;
    hold_b      = 1'b0;
    Send_in_a   = 1'b1;
    Send_in_b   = 1'b1;

    // Power-on reset: outputs idle and acks suppressed despite requests.
    repeat (3) @(posedge CLK);
    #2;
    check("rst_send_out", 32'(Send_out), 32'd0);
    check("rst_ack_a", 32'(Ack_out_a), 32'd0);
    check("rst_ack_b", 32'(Ack_out_b), 32'd0);
    check("rst_packet_out", 32'(PACKET_OUT), 32'd0);
    clear_sources();
    @(posedge CLK);
    #3;
    MR = 1'b1;

    // Contention from a fresh reset: a wins first, then strict alternation.
    src_a.push_back(24'h0000A1); src_a.push_back(24'h0000A2);
    src_b.push_back(24'h0000B1); src_b.push_back(24'h0000B2);
    repeat (8) step(100, 100);

    // Single source streaming back-to-back.
    src_a.push_back(24'h000011); src_a.push_back(24'h000022); src_a.push_back(24'h000033);
    repeat (6) step(100, 100);

    // Backpressure: fill, one pop, then the third packet gets in.
    src_a.push_back(24'h000101); src_a.push_back(24'h000202); src_a.push_back(24'h000303);
    repeat (5) step(100, 0);
    step(100, 100);
    repeat (3) step(100, 0);
    repeat (5) step(100, 100);

    // Tag option exercise (plain payload check when untagged).
    src_b.push_back(24'h000055);
    repeat (3) step(100, 100);
    src_a.push_back(24'h000066);
    repeat (3) step(100, 100);

    // Random traffic with random stalls.
    for (int i = 0; i < 40; i++) begin
      src_a.push_back(PW'($urandom));
      src_b.push_back(PW'($urandom));
    end
    repeat (150) step(60, 60);
    repeat (30) step(100, 100);
    check("drain_src_a", 32'(src_a.size()), 32'd0);
    check("drain_src_b", 32'(src_b.size()), 32'd0);

    // Mid-stream reset with a full buffer and a pending request.
    src_a.push_back(24'h000701); src_a.push_back(24'h000702); src_a.push_back(24'h000703);
    repeat (5) step(100, 0);
    @(posedge CLK);
    #3;
    MR = 1'b0;
    #1;
    check("mid_rst_send_out", 32'(Send_out), 32'd0);
    check("mid_rst_ack_a", 32'(Ack_out_a), 32'd0);
    check("mid_rst_packet_out", 32'(PACKET_OUT), 32'd0);
    clear_sources();
    repeat (2) @(posedge CLK);
    #3;
    MR = 1'b1;
    src_a.push_back(24'h00000A);
    repeat (5) step(100, 100);
    check("post_rst_src_a", 32'(src_a.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
